// File: rtl/clock_domain_exporter_if.sv
// Crossing bundles between the exporter (source domain) and the importer
// (destination domain). Exp carries the toggled request and its payload,
// Imp carries the toggled acknowledge back.
interface iClockDomain_Exp #(
    parameter int pBits = 8
);
    logic             req;
    logic [pBits-1:0] data;

    modport master (output req, output data);
    modport slave  (input  req, input  data);
endinterface

interface iClockDomain_Imp;
    logic ack;

    modport master (output ack);
    modport slave  (input  ack);
endinterface

// File: rtl/clock_domain_exporter.sv
// Source side of a req/ack toggle CDC. Local words are queued in a small
// FIFO and launched one at a time: data and req change on the same edge,
// then the next launch waits until the synchronised ack matches req.
module clock_domain_exporter #(
    parameter int pBits  = 8,
    parameter int pDepth = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stb,
    input  logic [pBits-1:0]         data,
    output logic                     ready,
    output logic [$clog2(pDepth):0]  level,
    output logic                     busy,
    output logic                     overflow,
    iClockDomain_Exp.master          cd_e,
    iClockDomain_Imp.slave           cd_i
);
    localparam int AW = $clog2(pDepth);
    localparam logic [AW:0] FULL = (AW+1)'(pDepth);

    logic [pBits-1:0] mem [pDepth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [1:0]       ack_ff;
    logic             ack_sync;
    logic             push;
    logic             pop;

    assign ack_sync = ack_ff[0];
    assign busy     = cd_e.req != ack_sync;
    // Full blocks a push even if a launch frees a slot on the same edge.
    assign ready    = count != FULL;
    assign level    = count;
    assign push     = stb && ready;
    assign pop      = !busy && (count != '0);

    // Two-flop synchroniser for the asynchronous ack toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ack_ff <= '0;
        else     ack_ff <= {cd_i.ack, ack_ff[1]};
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data;
    end

    // Pointers and occupancy; pointers wrap naturally at pDepth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Launch: payload and toggled request leave together and then hold
    // until the round trip completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cd_e.req  <= 1'b0;
            cd_e.data <= '0;
        end else if (pop) begin
            cd_e.req  <= ~cd_e.req;
            cd_e.data <= mem[rd_ptr];
        end
    end

    // Sticky flag for words dropped because the FIFO was full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               overflow <= 1'b0;
        else if (stb && !ready) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_clock_domain_exporter.sv
// Scoreboard bench: accepted words are queued as expected deliveries, and a
// monitor pops and compares them whenever the DUT toggles req. A behavioural
// model of occupancy, synchronised ack and the sticky flag checks the status
// outputs every cycle.
module tb_clock_domain_exporter;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       stb;
    logic [7:0] din;
    logic       ready;
    logic [2:0] level;
    logic       busy;
    logic       overflow;
    logic       ack;

    iClockDomain_Exp #(.pBits(8)) cd_e ();
    iClockDomain_Imp              cd_i ();
    assign cd_i.ack = ack;

    clock_domain_exporter #(.pBits(8), .pDepth(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .stb      (stb),
        .data     (din),
        .ready    (ready),
        .level    (level),
        .busy     (busy),
        .overflow (overflow),
        .cd_e     (cd_e.master),
        .cd_i     (cd_i.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Importer model: answers a req toggle after ack_delay negedges unless held.
    int ack_delay = 2;
    bit ack_hold  = 1'b0;
    initial begin
        int cnt = 0;
        ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ack = 1'b0;
                cnt = 0;
            end else if (cd_e.req != ack) begin
                if (!ack_hold && cnt >= ack_delay) begin
                    ack = cd_e.req;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Reference model + monitor, evaluated just after each rising edge.
    logic [7:0] mq[$];
    logic       m_req, m_ovf, a0, a1;
    logic [7:0] m_data;
    initial begin
        int  lvl;
        bit  launch, accept;
        logic [7:0] exp_w;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mq.delete();
                m_req = 0; m_data = 0; m_ovf = 0; a0 = 0; a1 = 0;
            end else begin
                lvl    = mq.size();
                launch = (m_req == a0) && (lvl > 0);
                accept = stb && (lvl < DEPTH);
                if (stb && !accept) m_ovf = 1'b1;
                if (launch) begin
                    m_req  = ~m_req;
                    exp_w  = mq.pop_front();
                    m_data = exp_w;
                    chk("launch_data", 32'(cd_e.data), 32'(exp_w));
                end else begin
                    chk("data_hold", 32'(cd_e.data), 32'(m_data));
                end
                if (accept) mq.push_back(din);
                a0 = a1;
                a1 = ack;
                chk("req",      32'(cd_e.req), 32'(m_req));
                chk("level",    32'(level),    32'(mq.size()));
                chk("ready",    32'(ready),    32'(mq.size() != DEPTH));
                chk("busy",     32'(busy),     32'(m_req != a0));
                chk("overflow", 32'(overflow), 32'(m_ovf));
            end
        end
    end

    task automatic cyc(input logic s, input logic [7:0] d);
        @(negedge clk);
        stb = s;
        din = d;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00);
    endtask

    initial begin
        rst = 1'b1;
        stb = 1'b0;
        din = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_req",      32'(cd_e.req),  32'd0);
        chk("rst_data",     32'(cd_e.data), 32'd0);
        chk("rst_ready",    32'(ready),     32'd1);
        chk("rst_level",    32'(level),     32'd0);
        chk("rst_busy",     32'(busy),      32'd0);
        chk("rst_overflow", 32'(overflow),  32'd0);

        // single word
        ack_delay = 2;
        cyc(1'b1, 8'hA5);
        idle(12);

        // burst with a 3-cycle importer
        ack_delay = 3;
        for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i));
        idle(50);

        // full FIFO and overflow while ack is held
        ack_hold = 1'b1;
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'h10 + 8'(i));
        cyc(1'b0, 8'h00);
        chk("full_level",    32'(level),    32'd4);
        chk("full_ready",    32'(ready),    32'd0);
        chk("full_overflow", 32'(overflow), 32'd1);
        chk("full_busy",     32'(busy),     32'd1);
        idle(5);
        ack_hold = 1'b0;
        idle(60);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // random traffic: exercises simultaneous push/pop and pointer wrap
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) ack_delay = $urandom_range(0, 5);
            cyc(($urandom_range(0, 99) < 45), 8'($urandom));
        end
        idle(80);

        // slow importer
        ack_delay = 20;
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'hC0 + 8'(i));
        idle(120);
        chk("drained", 32'(mq.size()), 32'd0);

        // asynchronous reset mid-transfer
        ack_delay = 2;
        ack_hold  = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h30 + 8'(i));
        idle(3);
        chk("pre_rst_level", 32'(level), 32'd3);
        chk("pre_rst_busy",  32'(busy),  32'd1);
        #2;
        rst = 1'b1;
        ack = 1'b0;
        #1;
        chk("arst_req",      32'(cd_e.req),  32'd0);
        chk("arst_data",     32'(cd_e.data), 32'd0);
        chk("arst_level",    32'(level),     32'd0);
        chk("arst_busy",     32'(busy),      32'd0);
        chk("arst_overflow", 32'(overflow),  32'd0);
        chk("arst_ready",    32'(ready),     32'd1);
        ack_hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 8'h5A);
        idle(15);
        chk("final_drained", 32'(mq.size()), 32'd0);
        chk("final_req",     32'(cd_e.req),  32'd1);
        chk("final_data",    32'(cd_e.data), 32'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
